// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 8;
    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int IDX_W       = $clog2(NUM_BLOCKS);
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W       = 32;
    localparam int MADDR_W     = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_UPDATE    = 2'd3
    } state_e;

    // Pick byte 'off' out of a block; byte 0 lives in the low bits.
    function automatic logic [DATA_W-1:0] byte_sel(input logic [BLK_W-1:0] blk,
                                                   input logic [OFF_W-1:0] off);
        return blk[{off, 3'b000} +: DATA_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the cache lines.
// Latency: combinational read, writes land on the next posedge.
// Backpressure: none; a line fill takes priority over a byte write.
module dcache_array
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [BLK_W-1:0]  data_o,
    input  logic              byte_we_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] byte_i,
    input  logic              fill_we_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [BLK_W-1:0]  fill_data_i
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLK_W-1:0]      data_q [NUM_BLOCKS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Line state bits: cleared by reset, set clean by a fill, marked dirty by a store.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            data_q[idx_i] <= fill_data_i;
            tag_q[idx_i]  <= fill_tag_i;
        end else if (byte_we_i) begin
            data_q[idx_i][{off_i, 3'b000} +: DATA_W] <= byte_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Latency: hits complete same cycle; miss = [WB] + fetch + 1 update + 1 hit cycle.
// Backpressure: BUSYWAIT stalls the CPU on a miss; MEM_BUSYWAIT stretches memory ops.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [ADDR_W-1:0]  ADDRESS,
    input  logic [DATA_W-1:0]  WRITEDATA,
    output logic [DATA_W-1:0]  READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [MADDR_W-1:0] MEM_ADDRESS,
    output logic [BLK_W-1:0]   MEM_WRITEDATA,
    input  logic [BLK_W-1:0]   MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    state_e state_q, state_d;
    logic [BLK_W-1:0] fill_q, fill_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             line_valid, line_dirty, hit, req, byte_we, fill_we;
    logic [TAG_W-1:0] line_tag;
    logic [BLK_W-1:0] line_data;

    assign {req_tag, req_idx, req_off} = ADDRESS;
    assign hit = line_valid & (line_tag == req_tag);
    assign req = READ | WRITE;

    dcache_array u_array (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .idx_i       (req_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .byte_we_i   (byte_we),
        .off_i       (req_off),
        .byte_i      (WRITEDATA),
        .fill_we_i   (fill_we),
        .fill_tag_i  (req_tag),
        .fill_data_i (fill_q)
    );

    // State register; reset abandons any in-flight memory op.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Fill buffer captures the fetched block on the completing edge.
    always_ff @(posedge CLK) begin
        fill_q <= fill_d;
    end

    // Next state, CPU-side responses and memory-side strobes.
    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        BUSYWAIT      = 1'b0;
        READDATA      = '0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        byte_we       = 1'b0;
        fill_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                BUSYWAIT = req & ~hit;
                // A combined read+write is a store: no load data returned.
                if (READ && !WRITE) READDATA = byte_sel(line_data, req_off);
                byte_we = WRITE & hit;
                if (req && !hit)
                    state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag, req_idx};
                MEM_WRITEDATA = line_data;
                if (!MEM_BUSYWAIT) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {req_tag, req_idx};
                if (!MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                BUSYWAIT = 1'b1;
                fill_we  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
